// File: rtl/fp16_acc_bank_if.sv
// Stream interface for fp16_acc_bank: fp16 beat input, drain request and fp32 drain output.
interface fp16_acc_bank_if #(
  parameter int unsigned NumAcc = 16
);
  localparam int unsigned AddrW = $clog2(NumAcc);

  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_value;
  logic [AddrW-1:0] in_addr;
  logic             in_first;
  logic             drain;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [AddrW-1:0] out_addr;
  logic             out_last;
  logic             busy;

  modport master (
    output in_valid, in_value, in_addr, in_first, drain, out_ready,
    input  in_ready, out_valid, out_data, out_addr, out_last, busy
  );

  modport slave (
    input  in_valid, in_value, in_addr, in_first, drain, out_ready,
    output in_ready, out_valid, out_data, out_addr, out_last, busy
  );
endinterface

// File: rtl/fp16_acc_bank.sv
// Bank of fp32 accumulators fed by fp16 beats; drains all entries in index order, then clears.
module fp16_acc_bank #(
  parameter int unsigned  NumAcc = 16,
  localparam int unsigned AddrW  = $clog2(NumAcc)
) (
  input logic            clk_i,
  input logic            rst_i,
  fp16_acc_bank_if.slave bus
);

  typedef enum logic [1:0] {StAccum, StFlush, StDrain} state_e;

  // fp16 -> fp32 is exact; fp16 subnormals become fp32 normals.
  function automatic logic [31:0] fp16_to_fp32(input logic [15:0] h);
    int p;
    logic [22:0] f;
    if (h[14:10] == 5'h1f) return {h[15], 8'hff, h[9:0], 13'd0};
    if (h[14:10] == 5'h00) begin
      if (h[9:0] == 10'd0) return {h[15], 31'd0};
      p = 0;
      for (int i = 0; i < 10; i++) if (h[i]) p = i;
      f = {13'd0, h[9:0]} << (23 - p);
      return {h[15], 8'(p + 103), f};
    end
    return {h[15], {3'd0, h[14:10]} + 8'd112, h[9:0], 13'd0};
  endfunction

  // Binary32 add, round-to-nearest-even. Mantissa frame: [27] carry, [26] hidden, [2:0] G/R/S.
  function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [9:0]  ex, ey, e, d;
    logic [27:0] mx, my, s;
    logic [24:0] m;
    logic        sticky, up;
    if (a[30:23] == 8'hff && a[22:0] != 23'd0) return a | 32'h0040_0000;
    if (b[30:23] == 8'hff && b[22:0] != 23'd0) return b | 32'h0040_0000;
    if (a[30:0] == 31'h7f80_0000) begin
      if (b[30:0] == 31'h7f80_0000 && a[31] != b[31]) return 32'h7fc0_0000;
      return a;
    end
    if (b[30:0] == 31'h7f80_0000) return b;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    ex = (x[30:23] == 8'd0) ? 10'd1 : {2'd0, x[30:23]};
    ey = (y[30:23] == 8'd0) ? 10'd1 : {2'd0, y[30:23]};
    mx = {1'b0, x[30:23] != 8'd0, x[22:0], 3'd0};
    my = {1'b0, y[30:23] != 8'd0, y[22:0], 3'd0};
    d  = ex - ey;
    if (d > 10'd27) begin
      sticky = |my;
      my     = '0;
    end else begin
      sticky = |(my & ((28'd1 << d) - 28'd1));
      my     = my >> d;
    end
    my[0] = my[0] | sticky;
    e = ex;
    if (x[31] == y[31]) begin
      s = mx + my;
      if (s[27]) begin
        s = {1'b0, s[27:2], s[1] | s[0]};
        e = e + 10'd1;
      end
    end else begin
      s = mx - my;
      if (s == 28'd0) return 32'd0;
      for (int i = 0; i < 26; i++) begin
        if (!s[26] && e > 10'd1) begin
          s = s << 1;
          e = e - 10'd1;
        end
      end
    end
    up = s[2] & (s[1] | s[0] | s[3]);
    m  = {1'b0, s[26:3]} + {24'd0, up};
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'd1;
    end
    if (e >= 10'd255) return {x[31], 8'hff, 23'd0};
    // Hidden bit clear means the result stayed subnormal.
    return {x[31], m[23] ? e[7:0] : 8'h00, m[22:0]};
  endfunction

  state_e           state_q, state_d;
  logic             s1_valid_q, s1_first_q;
  logic [15:0]      s1_value_q;
  logic [AddrW-1:0] s1_addr_q;
  logic [31:0]      acc_q [NumAcc];
  logic [31:0]      acc_d [NumAcc];
  logic [AddrW-1:0] cnt_q, cnt_d, cnt_nxt;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [31:0]      out_data_q, out_data_d, add_sum;
  logic [AddrW-1:0] out_addr_q, out_addr_d;
  logic             accept, out_hs, last_hs;

  assign accept  = bus.in_valid && (state_q == StAccum);
  assign out_hs  = out_valid_q && bus.out_ready;
  assign last_hs = out_hs && out_last_q;
  assign cnt_nxt = cnt_q + AddrW'(1);

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_last  = out_last_q;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StAccum;
    else       state_q <= state_d;
  end

  // Next-state: drain request only honoured while accumulating.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum: if (bus.drain) state_d = StFlush;
      StFlush: state_d = StDrain;
      StDrain: if (last_hs) state_d = StAccum;
      default: state_d = StAccum;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    bus.in_ready = (state_q == StAccum);
    bus.busy     = (state_q != StAccum);
  end

  // Accumulator update and drain output next-state.
  always_comb begin
    acc_d   = acc_q;
    add_sum = fp32_add(fp16_to_fp32(s1_value_q), s1_first_q ? 32'd0 : acc_q[s1_addr_q]);
    if (s1_valid_q) acc_d[s1_addr_q] = add_sum;
    if (last_hs) begin
      for (int i = 0; i < NumAcc; i++) acc_d[i] = 32'd0;
    end
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    if (state_q == StFlush) begin
      // Read through acc_d so the beat retiring this cycle is included.
      cnt_d       = '0;
      out_valid_d = 1'b1;
      out_addr_d  = '0;
      out_data_d  = acc_d[0];
      out_last_d  = 1'b0;
    end else if (out_hs) begin
      cnt_d = cnt_nxt;
      if (out_last_q) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end else begin
        out_addr_d = cnt_nxt;
        out_data_d = acc_q[cnt_nxt];
        out_last_d = (cnt_nxt == AddrW'(NumAcc - 1));
      end
    end
  end

  // Datapath registers: input stage, accumulators, drain counter and output beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_value_q  <= '0;
      s1_addr_q   <= '0;
      for (int i = 0; i < NumAcc; i++) acc_q[i] <= 32'd0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_first_q <= bus.in_first;
        s1_value_q <= bus.in_value;
        s1_addr_q  <= bus.in_addr;
      end
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_fp16_acc_bank.sv
// Directed bench for fp16_acc_bank: accumulation, first-beat restart, drain order, back-pressure, reset.
module tb_fp16_acc_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [31:0] exp_acc [16];

  fp16_acc_bank_if #(.NumAcc(16)) bus ();

  fp16_acc_bank #(.NumAcc(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [3:0] addr, input logic [15:0] val, input logic first);
    bus.in_valid = 1'b1;
    bus.in_addr  = addr;
    bus.in_value = val;
    bus.in_first = first;
    step();
  endtask

  // Request a drain and check every beat against exp_acc; exp_acc is cleared afterwards.
  task automatic drain_run(input string tag, input bit rnd, input bit hold);
    int  idx = 0;
    int  cyc = 0;
    bit  rdy;
    bus.drain = 1'b1;
    step();
    bus.drain    = 1'b0;
    bus.in_valid = hold;
    bus.in_addr  = 4'd9;
    bus.in_first = 1'b0;
    bus.in_value = 16'h3C00;
    bus.out_ready = 1'b0;
    chk({tag, "_flush_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_flush_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_flush_valid"}, 32'(bus.out_valid), 32'd0);
    step();
    while (idx < 16 && cyc < 300) begin
      chk($sformatf("%s_valid%0d", tag, idx), 32'(bus.out_valid), 32'd1);
      chk($sformatf("%s_addr%0d", tag, idx), 32'(bus.out_addr), 32'(idx));
      chk($sformatf("%s_data%0d", tag, idx), bus.out_data, exp_acc[idx]);
      chk($sformatf("%s_last%0d", tag, idx), 32'(bus.out_last), 32'(idx == 15));
      chk($sformatf("%s_inrdy%0d", tag, idx), 32'(bus.in_ready), 32'd0);
      rdy = rnd ? ((cyc % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
      bus.out_ready = rdy;
      if (idx == 15 && rdy) bus.in_valid = 1'b0;
      if (rdy) idx++;
      step();
      cyc++;
    end
    chk({tag, "_all_beats"}, 32'(idx), 32'd16);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk({tag, "_end_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_end_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_hold_addr"}, 32'(bus.out_addr), 32'd15);
    chk({tag, "_hold_data"}, bus.out_data, exp_acc[15]);
    for (int i = 0; i < 16; i++) exp_acc[i] = 32'd0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) exp_acc[i] = 32'd0;
    bus.in_valid  = 1'b0;
    bus.in_value  = 16'h0;
    bus.in_addr   = 4'd0;
    bus.in_first  = 1'b0;
    bus.drain     = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_addr", 32'(bus.out_addr), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);

    // Immediate drain after reset: all zeros.
    drain_run("d0", 1'b0, 1'b0);

    // 1 + 1 + 2 back-to-back on one index.
    beat(4'd3, 16'h3C00, 1'b1);
    beat(4'd3, 16'h3C00, 1'b0);
    beat(4'd3, 16'h4000, 1'b0);
    bus.in_valid = 1'b0;
    exp_acc[3] = 32'h4080_0000;
    drain_run("b2b", 1'b0, 1'b0);

    // Two prior runs, then a first beat discards the old sum.
    beat(4'd5, 16'h4000, 1'b1);
    bus.in_valid = 1'b0;
    exp_acc[5] = 32'h4000_0000;
    drain_run("r1", 1'b0, 1'b0);
    beat(4'd5, 16'h4000, 1'b0);
    bus.in_valid = 1'b0;
    exp_acc[5] = 32'h4000_0000;
    drain_run("r2", 1'b0, 1'b0);
    beat(4'd5, 16'h4000, 1'b0);
    beat(4'd5, 16'h3C00, 1'b1);
    bus.in_valid = 1'b0;
    exp_acc[5] = 32'h3F80_0000;
    drain_run("first", 1'b0, 1'b0);

    // Beat accepted in the drain cycle; input held valid throughout the drain.
    bus.in_valid = 1'b1;
    bus.in_addr  = 4'd0;
    bus.in_value = 16'h3C00;
    bus.in_first = 1'b1;
    exp_acc[0] = 32'h3F80_0000;
    drain_run("same", 1'b0, 1'b1);
    drain_run("noacc", 1'b0, 1'b0);

    // Arithmetic corners under random back-pressure.
    beat(4'd1, 16'h0001, 1'b1);
    beat(4'd1, 16'h0001, 1'b0);
    beat(4'd2, 16'h4200, 1'b1);
    beat(4'd2, 16'hBC00, 1'b0);
    beat(4'd4, 16'h7C00, 1'b1);
    beat(4'd6, 16'h3C00, 1'b1);
    beat(4'd6, 16'h0003, 1'b0);
    beat(4'd7, 16'h3C00, 1'b1);
    beat(4'd7, 16'h0001, 1'b0);
    beat(4'd7, 16'h0001, 1'b0);
    beat(4'd10, 16'h7BFF, 1'b1);
    beat(4'd10, 16'h7BFF, 1'b0);
    beat(4'd11, 16'h3C00, 1'b1);
    beat(4'd11, 16'hBC00, 1'b0);
    beat(4'd12, 16'hC000, 1'b1);
    bus.in_valid = 1'b0;
    exp_acc[1]  = 32'h3400_0000;
    exp_acc[2]  = 32'h4000_0000;
    exp_acc[4]  = 32'h7F80_0000;
    exp_acc[6]  = 32'h3F80_0002;
    exp_acc[7]  = 32'h3F80_0000;
    exp_acc[10] = 32'h47FF_E000;
    exp_acc[11] = 32'h0000_0000;
    exp_acc[12] = 32'hC000_0000;
    drain_run("bp", 1'b1, 1'b0);

    // Asynchronous reset with the drain counter at 7.
    beat(4'd7, 16'h3C00, 1'b1);
    beat(4'd8, 16'h4000, 1'b1);
    bus.in_valid  = 1'b0;
    bus.drain     = 1'b1;
    step();
    bus.drain     = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("mid_addr", 32'(bus.out_addr), 32'd7);
    chk("mid_data", bus.out_data, 32'h3F80_0000);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_data", bus.out_data, 32'd0);
    chk("arst_addr", 32'(bus.out_addr), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    drain_run("post_rst", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
